// File: rtl/memory_arbiter_if.sv
// Processor/memory bus bundle for the unified-memory arbiter.
// The slave modport is the arbiter side; the master modport drives requests and models the memory.
interface memory_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-port memory, one access in flight,
// data first with a streak limit that forces a waiting fetch through.
module memory_arbiter #(
    parameter int MEM_LAT     = 2,
    parameter int MAX_DSTREAK = 4
) (
    input logic              clk,
    input logic              reset,
    memory_arbiter_if.slave  bus
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [CW-1:0] CNT_INIT   = CW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    typedef enum logic { IDLE, ACCESS } state_t;
    typedef enum logic { OWN_IF, OWN_D } owner_t;

    state_t        state, nstate;
    owner_t        owner;
    logic          owner_we;
    logic [CW-1:0] cnt;
    logic [SW-1:0] streak;
    logic          idle, done, gnt_i, gnt_d;
    logic          if_rvalid_q, d_rvalid_q;
    logic [31:0]   if_rdata_q, d_rdata_q;

    // Grants are suppressed while reset is asserted so the bus stays quiet.
    assign idle = (state == IDLE) && !reset;
    assign done = (state == ACCESS) && (cnt == '0);

    always_comb begin
        gnt_d = 1'b0;
        gnt_i = 1'b0;
        if (idle) begin
            if (bus.d_req && !(bus.if_req && streak == STREAK_MAX)) gnt_d = 1'b1;
            else if (bus.if_req)                                    gnt_i = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (gnt_d || gnt_i) nstate = ACCESS;
            ACCESS:  if (cnt == '0)      nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        bus.if_gnt    = gnt_i;
        bus.d_gnt     = gnt_d;
        bus.mem_en    = gnt_i || gnt_d;
        bus.mem_we    = gnt_d && bus.d_we;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (gnt_d) begin
            bus.mem_addr  = {bus.d_addr[31:2], 2'b00};
            bus.mem_wdata = bus.d_wdata;
        end else if (gnt_i) begin
            bus.mem_addr  = {bus.if_addr[31:2], 2'b00};
        end
        bus.busy      = (state == ACCESS);
        bus.if_rvalid = if_rvalid_q;
        bus.d_rvalid  = d_rvalid_q;
        bus.if_rdata  = if_rdata_q;
        bus.d_rdata   = d_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            owner       <= OWN_IF;
            owner_we    <= 1'b0;
            streak      <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_rvalid_q <= done && (owner == OWN_IF);
            d_rvalid_q  <= done && (owner == OWN_D);
            if (gnt_d || gnt_i) begin
                cnt      <= CNT_INIT;
                owner    <= gnt_d ? OWN_D : OWN_IF;
                owner_we <= gnt_d && bus.d_we;
            end else if (state == ACCESS && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            // Stores complete with a response but leave the load data register alone.
            if (done) begin
                if (owner == OWN_IF) if_rdata_q <= bus.mem_rdata;
                else if (!owner_we)  d_rdata_q  <= bus.mem_rdata;
            end
            if (gnt_i) begin
                streak <= '0;
            end else if (gnt_d) begin
                if (!bus.if_req)               streak <= '0;
                else if (streak != STREAK_MAX) streak <= streak + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a two-cycle-latency word memory model.
module tb_memory_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    memory_arbiter_if bus();

    memory_arbiter #(.MEM_LAT(2), .MAX_DSTREAK(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: access sampled at the grant edge, data visible two cycles after the grant cycle.
    logic [31:0] mem [0:255];
    logic [31:0] rd1 = '0, rd2 = '0;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = '0, ld_data = '0;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr[9:2]] <= ld_data;
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
            rd1 <= mem[bus.mem_addr[9:2]];
        end
        rd2 <= rd1;
    end
    assign bus.mem_rdata = rd2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        reset = 1'b1;
        bus.if_req = 1'($urandom_range(0, 1)); bus.if_addr = $urandom;
        bus.d_req = 1'($urandom_range(0, 1)); bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = $urandom; bus.d_wdata = $urandom;
        tick();
        bus.if_req = 1'b1; bus.d_req = 1'b1; bus.if_addr = $urandom; bus.d_addr = $urandom;
        @(negedge clk);
        outs = {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we, bus.busy};
        tests++; if (outs !== 32'd0) begin fails++; $display("FAIL reset_ctrl got=%h exp=0", outs); end
        tests++; if (bus.if_rdata !== 32'd0) begin fails++; $display("FAIL reset_if_rdata got=%h exp=0", bus.if_rdata); end
        tests++; if (bus.d_rdata !== 32'd0) begin fails++; $display("FAIL reset_d_rdata got=%h exp=0", bus.d_rdata); end
        tests++; if ({bus.mem_addr, bus.mem_wdata} !== 64'd0) begin fails++; $display("FAIL reset_mem_bus got=%h exp=0", {bus.mem_addr, bus.mem_wdata}); end
        tick();
        reset = 1'b0;
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++; if ({bus.mem_en, bus.busy} !== 2'b00) begin fails++; $display("FAIL post_reset_quiet c=%0d got=%b exp=00", c, {bus.mem_en, bus.busy}); end
            tick();
        end
    endtask

    task automatic test_fetch();
        preload(32'h10, 32'hE3A01005);
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0013;
        @(negedge clk);
        tests++; if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we} !== 4'b1010) begin fails++; $display("FAIL fetch_c0_ctrl got=%b exp=1010", {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we}); end
        tests++; if (bus.mem_addr !== 32'h10) begin fails++; $display("FAIL fetch_addr got=%h exp=00000010", bus.mem_addr); end
        tests++; if (bus.mem_wdata !== 32'h0) begin fails++; $display("FAIL fetch_wdata got=%h exp=0", bus.mem_wdata); end
        tick();
        bus.if_req = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            tests++; if ({bus.busy, bus.mem_en, bus.if_rvalid} !== 3'b100) begin fails++; $display("FAIL fetch_busy c=%0d got=%b exp=100", c, {bus.busy, bus.mem_en, bus.if_rvalid}); end
            tick();
        end
        @(negedge clk);
        tests++; if ({bus.if_rvalid, bus.busy} !== 2'b10) begin fails++; $display("FAIL fetch_rvalid got=%b exp=10", {bus.if_rvalid, bus.busy}); end
        tests++; if (bus.if_rdata !== 32'hE3A01005) begin fails++; $display("FAIL fetch_rdata got=%h exp=e3a01005", bus.if_rdata); end
        tick();
        @(negedge clk);
        tests++; if (bus.if_rvalid !== 1'b0) begin fails++; $display("FAIL fetch_pulse got=%b exp=0", bus.if_rvalid); end
        tests++; if (bus.if_rdata !== 32'hE3A01005) begin fails++; $display("FAIL fetch_hold got=%h exp=e3a01005", bus.if_rdata); end
        tick();
    endtask

    task automatic test_priority();
        preload(32'h40, 32'h1234_5678);
        preload(32'h20, 32'hCAFE_F00D);
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
        @(negedge clk);
        tests++; if ({bus.d_gnt, bus.if_gnt} !== 2'b10) begin fails++; $display("FAIL prio_c0 got=%b exp=10", {bus.d_gnt, bus.if_gnt}); end
        tests++; if (bus.mem_addr !== 32'h40) begin fails++; $display("FAIL prio_daddr got=%h exp=00000040", bus.mem_addr); end
        tick();
        bus.d_req = 1'b0;
        @(negedge clk);
        tests++; if (bus.if_gnt !== 1'b0) begin fails++; $display("FAIL prio_wait_c1 got=%b exp=0", bus.if_gnt); end
        tick(); tick();
        @(negedge clk);
        tests++; if ({bus.d_rvalid, bus.if_gnt} !== 2'b11) begin fails++; $display("FAIL prio_c3 got=%b exp=11", {bus.d_rvalid, bus.if_gnt}); end
        tests++; if (bus.d_rdata !== 32'h1234_5678) begin fails++; $display("FAIL prio_drdata got=%h exp=12345678", bus.d_rdata); end
        tests++; if (bus.mem_addr !== 32'h20) begin fails++; $display("FAIL prio_iaddr got=%h exp=00000020", bus.mem_addr); end
        tick();
        bus.if_req = 1'b0;
        tick(); tick();
        @(negedge clk);
        tests++; if (bus.if_rvalid !== 1'b1) begin fails++; $display("FAIL prio_c6_rvalid got=%b exp=1", bus.if_rvalid); end
        tests++; if (bus.if_rdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL prio_irdata got=%h exp=cafef00d", bus.if_rdata); end
        tick();
    endtask

    task automatic test_store();
        preload(32'h44, 32'hAAAA_AAAA);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h44;
        tick();
        bus.d_req = 1'b0;
        tick(); tick();
        @(negedge clk);
        tests++; if (bus.d_rdata !== 32'hAAAA_AAAA) begin fails++; $display("FAIL store_prior got=%h exp=aaaaaaaa", bus.d_rdata); end
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h64; bus.d_wdata = 32'h7;
        @(negedge clk);
        tests++; if ({bus.d_gnt, bus.mem_en, bus.mem_we} !== 3'b111) begin fails++; $display("FAIL store_c0_ctrl got=%b exp=111", {bus.d_gnt, bus.mem_en, bus.mem_we}); end
        tests++; if (bus.mem_addr !== 32'h64) begin fails++; $display("FAIL store_addr got=%h exp=00000064", bus.mem_addr); end
        tests++; if (bus.mem_wdata !== 32'h7) begin fails++; $display("FAIL store_wdata got=%h exp=00000007", bus.mem_wdata); end
        tick();
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wdata = '0;
        tick(); tick();
        @(negedge clk);
        tests++; if (bus.d_rvalid !== 1'b1) begin fails++; $display("FAIL store_rvalid got=%b exp=1", bus.d_rvalid); end
        tests++; if (bus.d_rdata !== 32'hAAAA_AAAA) begin fails++; $display("FAIL store_rdata_kept got=%h exp=aaaaaaaa", bus.d_rdata); end
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h66;
        @(negedge clk);
        tests++; if ({bus.mem_addr, bus.mem_we} !== {32'h64, 1'b0}) begin fails++; $display("FAIL load_align got=%h exp=%h", {bus.mem_addr, bus.mem_we}, {32'h64, 1'b0}); end
        tick();
        bus.d_req = 1'b0;
        tick(); tick();
        @(negedge clk);
        tests++; if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'h7}) begin fails++; $display("FAIL load_back got=%h exp=%h", {bus.d_rvalid, bus.d_rdata}, {1'b1, 32'h7}); end
        tick();
    endtask

    task automatic test_starvation();
        logic exp_d, exp_i;
        bus.if_req = 1'b1; bus.if_addr = 32'h84;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80;
        for (int c = 0; c < 16; c++) begin
            exp_d = (c % 3 == 0) && (c != 12);
            exp_i = (c == 12);
            @(negedge clk);
            tests++; if ({bus.d_gnt, bus.if_gnt} !== {exp_d, exp_i}) begin fails++; $display("FAIL starve_c%0d got=%b exp=%b", c, {bus.d_gnt, bus.if_gnt}, {exp_d, exp_i}); end
            tick();
        end
        tests++; if (dut.streak !== 3'd1) begin fails++; $display("FAIL starve_streak got=%0d exp=1", dut.streak); end
        idle_inputs();
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid();
        preload(32'h30, 32'h0BAD_BEEF);
        bus.if_req = 1'b1; bus.if_addr = 32'h30;
        @(negedge clk);
        tests++; if (bus.if_gnt !== 1'b1) begin fails++; $display("FAIL rmid_gnt got=%b exp=1", bus.if_gnt); end
        tick();
        bus.if_req = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        tests++; if ({bus.busy, bus.if_rvalid} !== 2'b00) begin fails++; $display("FAIL rmid_c2 got=%b exp=00", {bus.busy, bus.if_rvalid}); end
        tick();
        bus.if_req = 1'b1;
        @(negedge clk);
        tests++; if ({bus.if_rvalid, bus.if_gnt} !== 2'b01) begin fails++; $display("FAIL rmid_c3 got=%b exp=01", {bus.if_rvalid, bus.if_gnt}); end
        tick();
        bus.if_req = 1'b0;
        tick(); tick();
        @(negedge clk);
        tests++; if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'h0BAD_BEEF}) begin fails++; $display("FAIL rmid_refetch got=%h exp=%h", {bus.if_rvalid, bus.if_rdata}, {1'b1, 32'h0BAD_BEEF}); end
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_starvation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
